// File: rtl/alu.sv
// Combinational ALU. bit 2 of alucontrol inverts b and injects a carry-in,
// so one adder serves add, subtract and set-less-than.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero
);

  // Result-select codes, taken from alucontrol[1:0]
  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_SUM = 2'b10;
  localparam logic [1:0] SEL_MSB = 2'b11;

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;

  // Conditionally inverted operand and shared adder. The carry out is dropped.
  // Set-less-than is the raw sign of a-b; signed overflow is not corrected.
  always_comb begin
    bb  = alucontrol[2] ? ~b : b;
    sum = a + bb + {{(WIDTH-1){1'b0}}, alucontrol[2]};
  end

  // Output select, with the zero flag derived from the same result
  always_comb begin
    aluresult = '0;
    case (alucontrol[1:0])
      SEL_AND: aluresult = a & bb;
      SEL_OR:  aluresult = a | bb;
      SEL_SUM: aluresult = sum;
      SEL_MSB: aluresult = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
      default: aluresult = '0;
    endcase
    zero = (aluresult == '0);
  end

endmodule

// File: rtl/flopenr.sv
// Register with load enable and asynchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d only when en is high; hold otherwise; reset wins over en and the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/flopr.sv
// Plain register with asynchronous active-high reset to zero.
module flopr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d on every rising edge; reset clears immediately and wins over the edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/alu_flop_block.sv
// Top-level slice: an ALU and two registers side by side. The three paths
// share only clk/reset; nothing is wired between them.
module alu_flop_block #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] aluresult,
  output logic             zero,
  input  logic [WIDTH-1:0] r_d,
  output logic [WIDTH-1:0] r_q,
  input  logic             en,
  input  logic [WIDTH-1:0] e_d,
  output logic [WIDTH-1:0] e_q
);

  alu #(.WIDTH(WIDTH)) u_alu (
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .aluresult  (aluresult),
    .zero       (zero)
  );

  flopr #(.WIDTH(WIDTH)) u_flopr (
    .clk   (clk),
    .reset (reset),
    .d     (r_d),
    .q     (r_q)
  );

  flopenr #(.WIDTH(WIDTH)) u_flopenr (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .d     (e_d),
    .q     (e_q)
  );

endmodule

// File: tb/tb_alu_flop_block.sv
// Self-checking bench for alu_flop_block: directed ALU table, randomized ALU
// against a reference model, register sequences and a randomized register run.
module tb_alu_flop_block;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] a, b;
  logic [2:0]   alucontrol;
  logic [W-1:0] aluresult;
  logic         zero;
  logic [W-1:0] r_d, r_q;
  logic         en;
  logic [W-1:0] e_d, e_q;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] exp_res;
    logic         exp_zero;
  } alu_vec_t;

  alu_vec_t vecs[12];

  alu_flop_block #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .aluresult  (aluresult),
    .zero       (zero),
    .r_d        (r_d),
    .r_q        (r_q),
    .en         (en),
    .e_d        (e_d),
    .e_q        (e_q)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference ALU: operations named by their arithmetic meaning
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic [2:0] op);
    logic [W-1:0] t;
    case (op)
      3'b010: return x + y;
      3'b110: return x - y;
      3'b000: return x & y;
      3'b001: return x | y;
      3'b100: return x & ~y;
      3'b101: return x | ~y;
      3'b111: begin t = x - y; return (t[W-1]) ? 1 : 0; end
      default: begin t = x + y; return (t[W-1]) ? 1 : 0; end
    endcase
  endfunction

  // Driver: apply ALU inputs and let them settle
  task automatic drive_alu(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op);
    a = x; b = y; alucontrol = op;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] mr, me, exp_r, rr;
    logic [2:0] op;
    n_checks = 0;
    n_fail = 0;

    vecs[0]  = '{32'h5, 32'h3, 3'b010, 32'h8, 1'b0};
    vecs[1]  = '{32'h5, 32'h3, 3'b110, 32'h2, 1'b0};
    vecs[2]  = '{32'h5, 32'h3, 3'b000, 32'h1, 1'b0};
    vecs[3]  = '{32'h5, 32'h3, 3'b001, 32'h7, 1'b0};
    vecs[4]  = '{32'h5, 32'h3, 3'b111, 32'h0, 1'b1};
    vecs[5]  = '{32'hFFFFFFFF, 32'h1, 3'b111, 32'h1, 1'b0};
    vecs[6]  = '{32'h1234, 32'h1234, 3'b110, 32'h0, 1'b1};
    vecs[7]  = '{32'hFFFFFFFF, 32'h1, 3'b010, 32'h0, 1'b1};
    vecs[8]  = '{32'hFF, 32'h0F, 3'b100, 32'hF0, 1'b0};
    vecs[9]  = '{32'h0, 32'h0, 3'b101, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{32'h40000000, 32'h40000000, 3'b011, 32'h1, 1'b0};
    vecs[11] = '{32'h80000000, 32'h1, 3'b111, 32'h0, 1'b1};

    // Reset phase; ALU must keep working while reset is high
    reset = 1'b1; en = 1'b1; r_d = 32'hFFFFFFFF; e_d = 32'hFFFFFFFF;
    a = '0; b = '0; alucontrol = 3'b000;
    tick(); tick();
    check("reset_r_q", r_q, '0);
    check("reset_e_q", e_q, '0);
    drive_alu(32'h5, 32'h3, 3'b010);
    check("alu_during_reset", aluresult, 32'h8);
    check("zero_during_reset", {31'b0, zero}, 32'h0);

    @(negedge clk);
    reset = 1'b0; en = 1'b0; r_d = '0; e_d = '0;

    // Directed ALU table
    for (int i = 0; i < 12; i++) begin
      drive_alu(vecs[i].a, vecs[i].b, vecs[i].op);
      check($sformatf("alu_vec%0d_res", i), aluresult, vecs[i].exp_res);
      check($sformatf("alu_vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
    end

    // Randomized ALU against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] x, y, e;
      x = $urandom();
      y = (i % 10 == 0) ? x : $urandom();
      op = 3'($urandom_range(0, 7));
      drive_alu(x, y, op);
      e = ref_alu(x, y, op);
      check($sformatf("alu_rand op=%b a=%h b=%h", op, x, y), aluresult, e);
      check("alu_rand_zero", {31'b0, zero}, {31'b0, (e == '0)});
    end

    // flopr: value not visible until the edge
    @(negedge clk);
    r_d = 32'hDEADBEEF;
    #1;
    check("flopr_before_edge", r_q, '0);
    tick();
    check("flopr_after_edge", r_q, 32'hDEADBEEF);

    // flopenr: load, then hold across two disabled edges
    @(negedge clk);
    e_d = 32'hA5A5A5A5; en = 1'b1;
    tick();
    check("flopenr_load", e_q, 32'hA5A5A5A5);
    @(negedge clk);
    e_d = 32'h11111111; en = 1'b0;
    tick(); tick();
    check("flopenr_hold", e_q, 32'hA5A5A5A5);
    check("flopr_tracks", r_q, 32'hDEADBEEF);

    // Mid-cycle reset clears both registers without an edge
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("async_reset_r_q", r_q, '0);
    check("async_reset_e_q", e_q, '0);

    // Reset priority over en and clock edges, then normal load on release
    en = 1'b1; e_d = 32'hFFFFFFFF; r_d = 32'hFFFFFFFF;
    tick(); tick();
    check("prio_r_q", r_q, '0);
    check("prio_e_q", e_q, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_no_edge_r_q", r_q, '0);
    tick();
    check("release_r_q", r_q, 32'hFFFFFFFF);
    check("release_e_q", e_q, 32'hFFFFFFFF);

    // Randomized register run with a behavioural model and expected queue
    mr = r_q; me = e_q;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rr = $urandom();
      r_d = rr;
      e_d = $urandom();
      en = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 19) == 0);
      if (reset) begin mr = '0; me = '0; end
      else begin
        mr = rr;
        if (en) me = e_d;
      end
      exp_q.push_back(mr);
      tick();
      exp_r = exp_q.pop_front();
      check($sformatf("rand_r_q cyc %0d", i), r_q, exp_r);
      check($sformatf("rand_e_q cyc %0d", i), e_q, me);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
